// File: rtl/sram_pkg.sv
// Shared SRAM array constants, analog rail levels and the row-access state encoding.
package sram_pkg;
  localparam int ROWS  = 6;
  localparam int ROW_W = $clog2(ROWS);

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  typedef enum logic [2:0] {IDLE, PRE, WL, SENSE, REC, DONE} acc_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/row_access_ctrl_phase_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load_i)         cnt_q <= value_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/row_access_ctrl.sv
// Sequences one SRAM row access: precharge, wordline, optional sense, recovery, done.
// All strobes and select levels are registered from the next state.
module row_access_ctrl
  import sram_pkg::*;
#(
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 3,
  parameter int SAE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ROW_W-1:0] req_row,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             dec_enable,
  output real              row_sel [0:ROW_W-1],
  output logic             pre_en,
  output logic             sae_en,
  output logic             wr_en
);
  localparam int CW = $clog2(max3(PRE_CYC, WL_CYC, SAE_CYC) + 1);
  localparam logic [ROW_W:0] ROWS_L = ROWS[ROW_W:0];

  acc_state_t       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             we_q, we_d, oor_q, oor_d;
  logic             ld;
  logic [CW-1:0]    ld_val;
  logic             expired;
  logic [ROW_W-1:0] sel_q;
  logic             ready_q, busy_q, done_q, err_q, dec_q, pre_q, sae_q, wr_q;

  phase_timer #(.W(CW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (ld),
    .value_i   (ld_val),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    we_d    = we_q;
    oor_d   = oor_q;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        row_d = req_row;
        we_d  = req_we;
        if ({1'b0, req_row} >= ROWS_L) begin
          oor_d   = 1'b1;
          state_d = DONE;
        end else begin
          oor_d   = 1'b0;
          state_d = PRE;
          ld      = 1'b1;
          ld_val  = CW'(PRE_CYC - 1);
        end
      end
      PRE: if (expired) begin
        state_d = WL;
        ld      = 1'b1;
        ld_val  = CW'(WL_CYC - 1);
      end
      WL: if (expired) begin
        if (we_q) state_d = REC;
        else begin
          state_d = SENSE;
          ld      = 1'b1;
          ld_val  = CW'(SAE_CYC - 1);
        end
      end
      SENSE:   if (expired) state_d = REC;
      REC:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select lines stay valid through REC so the wordline drops before the row changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      sel_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dec_q   <= 1'b0;
      pre_q   <= 1'b0;
      sae_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
      sel_q   <= (state_d inside {PRE, WL, SENSE, REC}) ? row_d : '0;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == DONE) && oor_d;
      dec_q   <= (state_d inside {WL, SENSE});
      pre_q   <= (state_d == PRE);
      sae_q   <= (state_d == SENSE);
      wr_q    <= (state_d == WL) && we_d;
    end
  end

  always_comb begin
    for (int i = 0; i < ROW_W; i++) row_sel[i] = sel_q[i] ? VDD : VSS;
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dec_enable = dec_q;
  assign pre_en     = pre_q;
  assign sae_en     = sae_q;
  assign wr_en      = wr_q;
endmodule

// File: tb/tb_row_access_ctrl.sv
// Randomized and directed bench for row_access_ctrl against a phase-arithmetic model.
module tb_row_access_ctrl;
  import sram_pkg::*;

  localparam int P = 2, W = 3, S = 2;
  localparam int OW = 8 + 2 * ROW_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_we = 1'b0;
  logic [ROW_W-1:0] req_row = '0;
  logic             req_ready, busy, done, err, dec_enable, pre_en, sae_en, wr_en;
  real              row_sel [0:ROW_W-1];

  int checks = 0;
  int fails  = 0;

  row_access_ctrl #(.PRE_CYC(P), .WL_CYC(W), .SAE_CYC(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_row    (req_row),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dec_enable (dec_enable),
    .row_sel    (row_sel),
    .pre_en     (pre_en),
    .sae_en     (sae_en),
    .wr_en      (wr_en)
  );

  always #5 clk = ~clk;

  // Packed view: {ready,busy,done,err,dec,pre,sae,wr, sel[MSB..0]}; sel 10=VDD, 01=VSS, 11=other.
  function automatic logic [OW-1:0] observe();
    logic [2*ROW_W-1:0] s;
    for (int i = 0; i < ROW_W; i++)
      s[2*i +: 2] = (row_sel[i] == VDD) ? 2'b10 : (row_sel[i] == VSS) ? 2'b01 : 2'b11;
    return {req_ready, busy, done, err, dec_enable, pre_en, sae_en, wr_en, s};
  endfunction

  function automatic int lat(input bit we, input int row);
    if (row >= ROWS) return 1;
    return we ? P + W + 2 : P + W + S + 2;
  endfunction

  // Expected outputs n cycles after acceptance (n=0 or past the end: idle).
  function automatic logic [OW-1:0] model(input int n, input bit we, input int row);
    logic [7:0]         f;
    logic [2*ROW_W-1:0] s_vss, s_row;
    int L;
    L = lat(we, row);
    for (int i = 0; i < ROW_W; i++) begin
      s_vss[2*i +: 2] = 2'b01;
      s_row[2*i +: 2] = row[i] ? 2'b10 : 2'b01;
    end
    if (n < 1 || n > L)            return {8'b1000_0000, s_vss};
    if (row >= ROWS)               return {8'b0111_0000, s_vss};
    if (n <= P)                    return {8'b0100_0100, s_row};
    if (n <= P + W) begin
      f = 8'b0100_1000; f[0] = we; return {f, s_row};
    end
    if (!we && n <= P + W + S)     return {8'b0100_1010, s_row};
    if (n == L - 1)                return {8'b0100_0000, s_row};
    return {8'b0110_0000, s_vss};
  endfunction

  task automatic test_reset();
    logic [OW-1:0] exp_v;
    rst_n = 1'b0; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_v = model(0, 1'b0, 0);
    checks++;
    if (observe() !== exp_v) begin
      fails++; $display("FAIL reset got=%b exp=%b", observe(), exp_v);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_access(input bit we, input int row);
    int k;
    int L;
    logic [OW-1:0] exp_v;
    k = 0;
    while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
    checks++;
    if (!req_ready) begin
      fails++; $display("FAIL ready_wait row=%0d got=%b exp=1", row, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_row = ROW_W'(row);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_row = ROW_W'($urandom);
    L = lat(we, row);
    for (int n = 1; n <= L + 1; n++) begin
      exp_v = model(n, we, row);
      checks++;
      if (observe() !== exp_v) begin
        fails++;
        $display("FAIL access we=%0d row=%0d n=%0d got=%b exp=%b", we, row, n, observe(), exp_v);
      end
      if (n <= L) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_random(input int count);
    for (int i = 0; i < count; i++) test_access(1'($urandom), int'($urandom_range(0, 7)));
  endtask

  task automatic test_back_to_back(input int r1, input int r2);
    int L;
    logic [OW-1:0] exp_v;
    L = lat(1'b0, r1);
    req_valid = 1'b1; req_we = 1'b0; req_row = ROW_W'(r1);
    @(posedge clk); #1;
    req_row = ROW_W'(r2);
    for (int n = 1; n <= L + 1; n++) begin
      exp_v = model(n, 1'b0, r1);
      checks++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL b2b_first n=%0d got=%b exp=%b", n, observe(), exp_v);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    L = lat(1'b0, r2);
    for (int n = 1; n <= L + 1; n++) begin
      exp_v = model(n, 1'b0, r2);
      checks++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL b2b_second n=%0d got=%b exp=%b", n, observe(), exp_v);
      end
      if (n <= L) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_mid_reset();
    logic [OW-1:0] exp_v;
    req_valid = 1'b1; req_we = 1'b0; req_row = ROW_W'(3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 1; n <= P + 2; n++) begin
      exp_v = model(n, 1'b0, 3);
      checks++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL midrst_pre n=%0d got=%b exp=%b", n, observe(), exp_v);
      end
      if (n < P + 2) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp_v = model(0, 1'b0, 3);
      checks++;
      if (observe() !== exp_v) begin
        fails++; $display("FAIL midrst_abort c=%0d got=%b exp=%b", c, observe(), exp_v);
      end
      @(posedge clk); #1;
    end
    test_access(1'b0, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_access(1'b0, 5);
    test_access(1'b1, 0);
    test_access(1'b0, 7);
    test_access(1'b1, 6);
    test_access(1'b1, 5);
    test_random(24);
    test_back_to_back(2, 5);
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
